// File: rtl/median_pkg.sv
// Shared types and constants for the median window feeder and its line buffer.
package median_pkg;

  localparam int DW_DEFAULT = 8;
  localparam int WIN_N      = 9;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    WAIT
  } state_t;

endpackage

// File: rtl/median_line_buffer.sv
// Two line buffers sharing one address; reads return the contents before this cycle's write.
module median_line_buffer #(
  parameter  int IMG_W = 16,
  parameter  int DW    = 8,
  localparam int AW    = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] rd0,
  output logic [DW-1:0] rd1
);

  logic [DW-1:0] lb0 [IMG_W];
  logic [DW-1:0] lb1 [IMG_W];

  assign rd0 = lb0[addr];
  assign rd1 = lb1[addr];

  // NOTE: the arrays carry no reset; row/col gating keeps stale data from ever being emitted.
  always_ff @(posedge clk) begin
    if (we) begin
      lb1[addr] <= lb0[addr];
      lb0[addr] <= din;
    end
  end

endmodule

// File: rtl/median_window_feeder.sv
// Builds 3x3 neighbourhoods from a raster stream and serialises each one as a 9-sample burst.
module median_window_feeder
  import median_pkg::*;
#(
  parameter int IMG_W = 16,
  parameter int DW    = DW_DEFAULT
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [DW-1:0] PI,
  input  logic          PVAL,
  input  logic          FSTART,
  output logic          PRDY,
  output logic [DW-1:0] DO,
  output logic          DSO,
  input  logic          MDONE
);

  localparam int AW = $clog2(IMG_W);

  state_t        state, state_nxt;
  logic [AW-1:0] col, col_nxt, pos_col;
  logic [1:0]    row, row_nxt, pos_row;
  logic [3:0]    idx, idx_nxt;
  logic [DW-1:0] do_nxt;
  logic          dso_nxt;
  logic          accept, emit;
  logic [DW-1:0] lb0_rd, lb1_rd;
  logic [DW-1:0] win [WIN_N];

  assign PRDY    = (state == IDLE) && !RST;
  assign accept  = PVAL && PRDY;
  assign pos_col = FSTART ? '0 : col;
  assign pos_row = FSTART ? 2'd0 : row;
  assign emit    = (pos_row == 2'd2) && (pos_col >= AW'(2));

  median_line_buffer #(.IMG_W(IMG_W), .DW(DW)) u_lb (
    .clk  (CLK),
    .we   (accept),
    .addr (pos_col),
    .din  (PI),
    .rd0  (lb0_rd),
    .rd1  (lb1_rd)
  );

  // NOTE: every signal gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    idx_nxt   = idx;
    do_nxt    = DO;
    dso_nxt   = DSO;
    unique case (state)
      IDLE: begin
        if (accept) begin
          // A frame-start pixel sits at (0,0), so the same update yields col=1,row=0.
          if (pos_col == AW'(IMG_W - 1)) begin
            col_nxt = '0;
            row_nxt = (pos_row == 2'd2) ? 2'd2 : pos_row + 2'd1;
          end else begin
            col_nxt = pos_col + 1'b1;
            row_nxt = pos_row;
          end
          if (emit) begin
            state_nxt = EMIT;
            idx_nxt   = '0;
          end
        end
      end
      EMIT: begin
        // The window is stored row-major, so idx addresses w[idx/3][idx%3] directly.
        do_nxt  = win[idx];
        dso_nxt = 1'b1;
        idx_nxt = idx + 4'd1;
        if (idx == 4'(WIN_N - 1)) state_nxt = WAIT;
      end
      WAIT: begin
        dso_nxt = 1'b0;
        if (MDONE) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      DO    <= '0;
      DSO   <= 1'b0;
      col   <= '0;
      row   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      DO    <= do_nxt;
      DSO   <= dso_nxt;
      col   <= col_nxt;
      row   <= row_nxt;
      idx   <= idx_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win[3*r]     <= win[3*r + 1];
        win[3*r + 1] <= win[3*r + 2];
      end
      win[2] <= lb1_rd;
      win[5] <= lb0_rd;
      win[8] <= PI;
    end
  end

endmodule

// File: tb/tb_median_window_feeder.sv
// Directed bench for median_window_feeder with IMG_W=4 and hand-computed windows.
module tb_median_window_feeder;
  import median_pkg::*;

  localparam int IMG_W = 4;
  localparam int DW    = 8;

  typedef logic [DW-1:0] win_t [WIN_N];

  logic          CLK;
  logic          RST;
  logic [DW-1:0] PI;
  logic          PVAL;
  logic          FSTART;
  logic          PRDY;
  logic [DW-1:0] DO;
  logic          DSO;
  logic          MDONE;

  int vectors = 0;
  int errors  = 0;

  median_window_feeder #(.IMG_W(IMG_W), .DW(DW)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .PI     (PI),
    .PVAL   (PVAL),
    .FSTART (FSTART),
    .PRDY   (PRDY),
    .DO     (DO),
    .DSO    (DSO),
    .MDONE  (MDONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_px(input logic [DW-1:0] v, input logic fs);
    int n;
    n      = 0;
    PI     = v;
    PVAL   = 1'b1;
    FSTART = fs;
    while (!PRDY && n < 50) begin
      step();
      n++;
    end
    chk("prdy_wait", {31'd0, PRDY}, 32'd1);
    step();
    PVAL   = 1'b0;
    FSTART = 1'b0;
  endtask

  task automatic send_quiet(input logic [DW-1:0] v, input logic fs);
    send_px(v, fs);
    chk("no_emit_prdy", {31'd0, PRDY}, 32'd1);
    chk("no_emit_dso", {31'd0, DSO}, 32'd0);
  endtask

  task automatic expect_window(input win_t e, input logic early_mdone);
    for (int i = 0; i < WIN_N; i++) begin
      MDONE = early_mdone && (i == 2);
      step();
      chk("burst_do", {24'd0, DO}, {24'd0, e[i]});
      chk("burst_dso", {31'd0, DSO}, 32'd1);
    end
    MDONE = 1'b0;
    step();
    chk("burst_end_dso", {31'd0, DSO}, 32'd0);
    chk("burst_end_prdy", {31'd0, PRDY}, 32'd0);
  endtask

  task automatic mdone_pulse();
    MDONE = 1'b1;
    step();
    MDONE = 1'b0;
    chk("release_prdy", {31'd0, PRDY}, 32'd1);
  endtask

  initial begin
    RST    = 1'b1;
    PVAL   = 1'b1;
    PI     = 8'hAA;
    FSTART = 1'b0;
    MDONE  = 1'b0;

    // Reset held for two edges with a pixel offered.
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_dso", {31'd0, DSO}, 32'd0);
      chk("rst_do", {24'd0, DO}, 32'd0);
      chk("rst_prdy", {31'd0, PRDY}, 32'd0);
    end
    RST  = 1'b0;
    PVAL = 1'b0;
    #1;
    chk("post_rst_prdy", {31'd0, PRDY}, 32'd1);

    // First window of a 4-wide frame.
    send_quiet(8'd0, 1'b1);
    for (int p = 1; p < 10; p++) send_quiet(DW'(p), 1'b0);
    send_px(8'd10, 1'b0);
    expect_window('{8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10}, 1'b0);

    // Stall with the next pixel held by the source.
    PI   = 8'd11;
    PVAL = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("stall_prdy", {31'd0, PRDY}, 32'd0);
      chk("stall_dso", {31'd0, DSO}, 32'd0);
    end
    mdone_pulse();
    send_px(8'd11, 1'b0);
    expect_window('{8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11}, 1'b1);
    mdone_pulse();

    // Row start: cols 0 and 1 never emit.
    send_quiet(8'd12, 1'b0);
    send_quiet(8'd13, 1'b0);
    send_px(8'd14, 1'b0);
    expect_window('{8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10, 8'd12, 8'd13, 8'd14}, 1'b0);
    mdone_pulse();

    // Reset during the fifth burst sample of the next window.
    send_px(8'd15, 1'b0);
    step(); chk("mid_do0", {24'd0, DO}, 32'd5);
    step(); chk("mid_do1", {24'd0, DO}, 32'd6);
    step(); chk("mid_do2", {24'd0, DO}, 32'd7);
    step(); chk("mid_do3", {24'd0, DO}, 32'd9);
    step(); chk("mid_do4", {24'd0, DO}, 32'd10);
    chk("mid_dso4", {31'd0, DSO}, 32'd1);
    RST = 1'b1;
    step();
    chk("mid_rst_dso", {31'd0, DSO}, 32'd0);
    chk("mid_rst_do", {24'd0, DO}, 32'd0);
    chk("mid_rst_prdy", {31'd0, PRDY}, 32'd0);
    RST = 1'b0;
    #1;
    chk("mid_rel_prdy", {31'd0, PRDY}, 32'd1);

    send_quiet(8'd0, 1'b1);
    for (int p = 1; p < 10; p++) send_quiet(DW'(p), 1'b0);
    send_px(8'd10, 1'b0);
    expect_window('{8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10}, 1'b0);
    mdone_pulse();

    // Partial frame, then a frame start mid-frame.
    send_quiet(8'd50, 1'b1);
    for (int p = 51; p < 56; p++) send_quiet(DW'(p), 1'b0);
    send_quiet(8'd100, 1'b1);
    for (int p = 101; p < 110; p++) send_quiet(DW'(p), 1'b0);
    send_px(8'd110, 1'b0);
    expect_window('{8'd100, 8'd101, 8'd102, 8'd104, 8'd105, 8'd106, 8'd108, 8'd109, 8'd110}, 1'b0);
    mdone_pulse();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
